// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the stopwatch controller and its divider/display neighbours.
// Optional LAP_EN adds the lap button.
interface stopwatch_ctrl_if;
  logic       one_hz;
  logic       disp_tick;
  logic       btn_pause;
  logic       btn_rst;
`ifdef LAP_EN
  logic       btn_lap;
`endif
  logic       sw_adj;
  logic       sw_sel;
  logic [1:0] div_state;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       blink;
  logic       running;

  modport master (
`ifdef LAP_EN
    output btn_lap,
`endif
    output one_hz, disp_tick, btn_pause, btn_rst, sw_adj, sw_sel,
    input  div_state, min_tens, min_ones, sec_tens, sec_ones, blink, running
  );

  modport slave (
`ifdef LAP_EN
    input  btn_lap,
`endif
    input  one_hz, disp_tick, btn_pause, btn_rst, sw_adj, sw_sel,
    output div_state, min_tens, min_ones, sec_tens, sec_ones, blink, running
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode FSM (RESET/PAUSE/RUN/ADJUST), button debounce and BCD MM:SS counting.
// Define LAP_EN to add a lap button that freezes the displayed digits while RUN continues.
module stopwatch_ctrl #(
  parameter int unsigned RESET_HOLD  = 2,
  parameter int unsigned DEB_SAMPLES = 2
) (
  input logic             clk,
  input logic             rst_n,
  stopwatch_ctrl_if.slave bus_io
);

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StPause  = 2'd1,
    StReset  = 2'd2,
    StAdjust = 2'd3
  } state_e;

`ifdef LAP_EN
  localparam int unsigned NumBtn = 3;
`else
  localparam int unsigned NumBtn = 2;
`endif
  localparam logic [2:0] DebCnt   = 3'(DEB_SAMPLES);
  localparam logic [3:0] HoldLast = 4'(RESET_HOLD - 1);

  function automatic logic [7:0] inc_bcd60(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  logic [NumBtn-1:0]      btn_raw, btn_s1_q, btn_s2_q, deb_q, deb_d, press_q;
  logic [NumBtn-1:0][2:0] cnt_q, cnt_d;
  logic [1:0]             sw_s1_q, sw_s2_q;
  logic                   one_hz_q, sec_evt;
  logic                   pause_press, rst_press, sw_adj, sw_sel;
  state_e                 state_q, state_d;
  logic [3:0]             hold_q, hold_d;
  logic [7:0]             sec_q, sec_d, min_q, min_d;
  logic                   blink_q, blink_d;
  logic [15:0]            disp;

  assign btn_raw[0] = bus_io.btn_pause;
  assign btn_raw[1] = bus_io.btn_rst;
`ifdef LAP_EN
  assign btn_raw[2] = bus_io.btn_lap;
`endif

  assign pause_press = press_q[0];
  assign rst_press   = press_q[1];
  assign sw_adj      = sw_s2_q[0];
  assign sw_sel      = sw_s2_q[1];
  assign sec_evt     = bus_io.one_hz & ~one_hz_q;

  // Level rises after DebCnt consecutive high samples, falls on the first low one.
  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    if (bus_io.disp_tick) begin
      for (int i = 0; i < NumBtn; i++) begin
        if (!btn_s2_q[i]) begin
          cnt_d[i] = '0;
          deb_d[i] = 1'b0;
        end else begin
          if (cnt_q[i] < DebCnt) cnt_d[i] = cnt_q[i] + 3'd1;
          deb_d[i] = (cnt_d[i] == DebCnt);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      cnt_q    <= '0;
      deb_q    <= '0;
      press_q  <= '0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      one_hz_q <= 1'b0;
    end else begin
      btn_s1_q <= btn_raw;
      btn_s2_q <= btn_s1_q;
      cnt_q    <= cnt_d;
      deb_q    <= deb_d;
      press_q  <= deb_d & ~deb_q;
      sw_s1_q  <= {bus_io.sw_sel, bus_io.sw_adj};
      sw_s2_q  <= sw_s1_q;
      one_hz_q <= bus_io.one_hz;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StReset;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      StReset: begin
        if (rst_press)                hold_d  = '0;
        else if (hold_q == HoldLast)  state_d = StPause;
        else                          hold_d  = hold_q + 4'd1;
      end
      StPause: begin
        if (rst_press)        state_d = StReset;
        else if (sw_adj)      state_d = StAdjust;
        else if (pause_press) state_d = StRun;
      end
      StRun: begin
        if (rst_press)        state_d = StReset;
        else if (sw_adj)      state_d = StAdjust;
        else if (pause_press) state_d = StPause;
      end
      StAdjust: begin
        if (rst_press)   state_d = StReset;
        else if (!sw_adj) state_d = StPause;
      end
      default: state_d = StReset;
    endcase
    if (state_d == StReset && state_q != StReset) hold_d = '0;
  end

  // Increments use the state of the current cycle even when it is being left.
  always_comb begin
    sec_d   = sec_q;
    min_d   = min_q;
    blink_d = blink_q;
    if (state_q == StReset || rst_press) begin
      sec_d = '0;
      min_d = '0;
    end else if (sec_evt) begin
      if (state_q == StRun) begin
        sec_d = inc_bcd60(sec_q);
        if (sec_q == 8'h59) min_d = inc_bcd60(min_q);
      end else if (state_q == StAdjust) begin
        if (sw_sel) min_d = inc_bcd60(min_q);
        else        sec_d = inc_bcd60(sec_q);
        blink_d = ~blink_q;
      end
    end
    if (state_d != StAdjust) blink_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_q   <= '0;
      min_q   <= '0;
      blink_q <= 1'b0;
    end else begin
      sec_q   <= sec_d;
      min_q   <= min_d;
      blink_q <= blink_d;
    end
  end

`ifdef LAP_EN
  logic        frozen_q, frozen_d;
  logic [15:0] snap_q, snap_d;

  always_comb begin
    frozen_d = frozen_q;
    snap_d   = snap_q;
    if (state_q == StRun && state_d == StRun && press_q[2]) begin
      frozen_d = ~frozen_q;
      if (!frozen_q) snap_d = {min_q, sec_q};
    end
    if (state_d != StRun) frozen_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frozen_q <= 1'b0;
      snap_q   <= '0;
    end else begin
      frozen_q <= frozen_d;
      snap_q   <= snap_d;
    end
  end

  assign disp = frozen_q ? snap_q : {min_q, sec_q};
`else
  assign disp = {min_q, sec_q};
`endif

  always_comb begin
    bus_io.div_state = state_q;
    bus_io.running   = (state_q == StRun);
    bus_io.blink     = blink_q;
    bus_io.min_tens  = disp[15:12];
    bus_io.min_ones  = disp[11:8];
    bus_io.sec_tens  = disp[7:4];
    bus_io.sec_ones  = disp[3:0];
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed plus randomized bench for stopwatch_ctrl against a seconds-level behavioural model.
module tb_stopwatch_ctrl;

  localparam int ResetHold  = 2;
  localparam int DebSamples = 2;
  localparam int MRun = 0, MPause = 1, MReset = 2, MAdjust = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  stopwatch_ctrl_if bus ();

  stopwatch_ctrl #(
    .RESET_HOLD (ResetHold),
    .DEB_SAMPLES(DebSamples)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode plus plain integer minutes/seconds.
  int m_mode, m_min, m_sec, m_snap_min, m_snap_sec;
  bit m_blink, m_adj, m_sel, m_frozen;

  task automatic m_clear();
    m_min = 0; m_sec = 0; m_blink = 0; m_frozen = 0;
  endtask

  task automatic m_pause();
    if (m_mode == MPause) m_mode = MRun;
    else if (m_mode == MRun) begin m_mode = MPause; m_frozen = 0; end
  endtask

  task automatic m_rst();
    m_clear();
    m_mode = m_adj ? MAdjust : MPause;
  endtask

  task automatic m_set_adj(input bit v);
    m_adj = v;
    if (v && (m_mode == MRun || m_mode == MPause)) begin
      m_mode = MAdjust; m_frozen = 0; m_blink = 0;
    end else if (!v && m_mode == MAdjust) begin
      m_mode = MPause; m_blink = 0;
    end
  endtask

  task automatic m_edge();
    if (m_mode == MRun) begin
      m_sec = m_sec + 1;
      if (m_sec == 60) begin m_sec = 0; m_min = (m_min + 1) % 60; end
    end else if (m_mode == MAdjust) begin
      if (m_sel) m_min = (m_min + 1) % 60;
      else       m_sec = (m_sec + 1) % 60;
      m_blink = ~m_blink;
    end
  endtask

  task automatic m_lap();
    if (m_mode == MRun) begin
      if (m_frozen) m_frozen = 0;
      else begin m_frozen = 1; m_snap_min = m_min; m_snap_sec = m_sec; end
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    int mm, ss;
    mm = m_frozen ? m_snap_min : m_min;
    ss = m_frozen ? m_snap_sec : m_sec;
    chk({tag, ".div_state"}, {2'b00, bus.div_state}, 4'(m_mode));
    chk({tag, ".running"}, {3'b000, bus.running}, {3'b000, m_mode == MRun});
    chk({tag, ".blink"}, {3'b000, bus.blink}, {3'b000, m_blink});
    chk({tag, ".min_tens"}, bus.min_tens, 4'(mm / 10));
    chk({tag, ".min_ones"}, bus.min_ones, 4'(mm % 10));
    chk({tag, ".sec_tens"}, bus.sec_tens, 4'(ss / 10));
    chk({tag, ".sec_ones"}, bus.sec_ones, 4'(ss % 10));
  endtask

  task automatic chk_digits(input string tag, input int mm, input int ss);
    chk({tag, ".mt"}, bus.min_tens, 4'(mm / 10));
    chk({tag, ".mo"}, bus.min_ones, 4'(mm % 10));
    chk({tag, ".st"}, bus.sec_tens, 4'(ss / 10));
    chk({tag, ".so"}, bus.sec_ones, 4'(ss % 10));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick();
    bus.disp_tick = 1'b1;
    idle(1);
    bus.disp_tick = 1'b0;
    idle(3);
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      0: bus.btn_pause = v;
      1: bus.btn_rst = v;
`ifdef LAP_EN
      2: bus.btn_lap = v;
`endif
      default: ;
    endcase
  endtask

  task automatic press(input int which);
    set_btn(which, 1'b1);
    idle(3);
    repeat (DebSamples + 1) tick();
    set_btn(which, 1'b0);
    idle(3);
    repeat (2) tick();
    idle(ResetHold + 4);
  endtask

  task automatic glitch(input int which);
    set_btn(which, 1'b1);
    idle(3);
    tick();
    set_btn(which, 1'b0);
    idle(3);
    repeat (2) tick();
  endtask

  task automatic sec_edges(input int n);
    repeat (n) begin
      bus.one_hz = 1'b1;
      idle(2);
      bus.one_hz = 1'b0;
      idle(2);
      m_edge();
    end
  endtask

  task automatic drive_adj(input bit v);
    bus.sw_adj = v;
    idle(6);
    m_set_adj(v);
  endtask

  task automatic drive_sel(input bit v);
    bus.sw_sel = v;
    idle(6);
    m_sel = v;
  endtask

  initial begin
    int op;
    bus.one_hz = 0; bus.disp_tick = 0; bus.btn_pause = 0; bus.btn_rst = 0;
    bus.sw_adj = 0; bus.sw_sel = 0;
`ifdef LAP_EN
    bus.btn_lap = 0;
`endif
    m_adj = 0; m_sel = 0; m_clear(); m_mode = MReset;
    idle(3);
    chk_model("in_reset");

    // Reset release: two cycles in RESET, then PAUSE.
    rst_n = 1'b1;
    chk("rel0.div", {2'b00, bus.div_state}, 4'd2);
    idle(1);
    chk("rel1.div", {2'b00, bus.div_state}, 4'd2);
    idle(1);
    chk("rel2.div", {2'b00, bus.div_state}, 4'd1);
    m_mode = MPause;
    chk_model("after_release");

    glitch(0);
    chk_model("glitch_in_pause");
    press(0); m_pause();
    chk("run.div", {2'b00, bus.div_state}, 4'd0);
    sec_edges(3);
    chk_digits("run3", 0, 3);
    chk_model("run3");
    glitch(0);
    chk_model("glitch_in_run");

    // Preload 59:58 through ADJUST, then roll over in RUN.
    drive_adj(1); drive_sel(0); sec_edges(55);
    drive_sel(1); sec_edges(59);
    drive_adj(0); press(0); m_pause();
    chk_model("preload");
    sec_edges(1); chk_digits("to5959", 59, 59);
    sec_edges(1); chk_digits("wrap", 0, 0);
    chk_model("wrap");

    // Minute field adjust from 58:10, seconds untouched.
    drive_adj(1); drive_sel(0); sec_edges(10);
    drive_sel(1); sec_edges(58);
    chk_model("adj5810");
    sec_edges(1); chk_digits("adj1", 59, 10); chk_model("adj1");
    sec_edges(1); chk_digits("adj2", 0, 10); chk_model("adj2");
    sec_edges(1); chk_digits("adj3", 1, 10); chk_model("adj3");
    drive_adj(0);
    chk("adj_exit.blink", {3'b000, bus.blink}, 4'd0);
    chk_model("adj_exit");

    // rst press coincident with sec_evt at 00:07.
    press(1); m_rst();
    press(0); m_pause();
    sec_edges(7);
    chk_digits("at0007", 0, 7);
    bus.btn_rst = 1'b1;
    idle(3);
    repeat (DebSamples - 1) tick();
    bus.disp_tick = 1'b1;
    idle(1);
    bus.disp_tick = 1'b0;
    bus.one_hz = 1'b1;
    idle(1);
    chk("coinc.div", {2'b00, bus.div_state}, 4'd2);
    chk_digits("coinc", 0, 0);
    idle(1);
    bus.one_hz = 1'b0;
    bus.btn_rst = 1'b0;
    idle(3);
    repeat (2) tick();
    idle(ResetHold + 4);
    m_rst();
    chk_model("after_coinc");

    // Randomized operations against the model.
    for (int k = 0; k < 80; k++) begin
      op = int'($urandom_range(0, 9));
      case (op)
        0, 1: begin press(0); m_pause(); end
        2: begin press(1); m_rst(); end
        3: drive_adj(~m_adj);
        4: drive_sel(~m_sel);
        5, 6: sec_edges(int'($urandom_range(1, 3)));
        7: glitch(int'($urandom_range(0, 1)));
`ifdef LAP_EN
        8: begin press(2); m_lap(); end
`else
        8: sec_edges(1);
`endif
        default: sec_edges(int'($urandom_range(4, 12)));
      endcase
      chk_model("rand");
    end

    // Asynchronous reset in RUN at 12:34.
    drive_adj(0); press(1); m_rst();
    drive_adj(1); drive_sel(1); sec_edges(12);
    drive_sel(0); sec_edges(34);
    drive_adj(0); press(0); m_pause();
    chk_digits("at1234", 12, 34);
    chk_model("at1234");
    #3 rst_n = 1'b0;
    #1;
    chk("async.div", {2'b00, bus.div_state}, 4'd2);
    chk_digits("async", 0, 0);
    idle(2);
    rst_n = 1'b1;
    idle(ResetHold + 6);
    m_clear(); m_mode = MPause;
    chk_model("after_async");

`ifdef LAP_EN
    press(0); m_pause();
    sec_edges(5);
    press(2); m_lap();
    sec_edges(4);
    chk_digits("lap_hold", 0, 5);
    chk_model("lap_hold");
    press(2); m_lap();
    chk_digits("lap_release", 0, 9);
    chk_model("lap_release");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Mode controller and time-keeping sequencer for the stopwatch datapath. It debounces user buttons, runs the RESET/PAUSE/RUN/ADJUST state machine, and drives the 2-bit state code into the clock divider. It consumes the divider's 1 Hz and display strobes to advance a BCD MM:SS count. Its outputs feed the seven-segment display mux.

Parameters:
RESET_HOLD, 2, clk cycles the FSM stays in RESET (divider sees state 2) before moving to PAUSE; legal range 1..15
DEB_SAMPLES, 2, consecutive disp_tick samples a button must read high to count as pressed; legal range 1..7

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
one_hz  in  1  1 Hz level from divider; rising edge = one second
disp_tick  in  1  single-cycle display strobe from divider; used as debounce sample enable
btn_pause  in  1  raw start/pause button
btn_rst  in  1  raw reset button
sw_adj  in  1  adjust-mode switch, level
sw_sel  in  1  adjust field select: 0 = seconds, 1 = minutes
div_state  out  2  state code to divider: 0 RUN, 1 PAUSE, 2 RESET, 3 ADJUST
min_tens  out  4  BCD 0..5
min_ones  out  4  BCD 0..9
sec_tens  out  4  BCD 0..5
sec_ones  out  4  BCD 0..9
blink  out  1  in ADJUST, toggles on each one_hz rising edge; 0 otherwise
running  out  1  1 only in RUN

Behaviour:
- rst_n low (async): FSM = RESET, hold counter = 0, all digits = 0, blink = 0, running = 0, div_state = 2, debounce state cleared.
- Buttons: 2-flop synchronizer on clk. On each disp_tick the synchronized level is shifted into a per-button counter. The debounced level rises after DEB_SAMPLES consecutive high samples and falls on the first low sample. A press is a 1-cycle pulse on the debounced rising edge. sw_adj and sw_sel are 2-flop synchronized only.
- one_hz edge: sec_evt = one_hz & ~one_hz_q, where one_hz_q is registered. Same clock domain, no synchronizer.
- FSM, with priority per cycle: rst press > sw_adj > pause press.
  RESET: digits forced 0; hold counter increments each cycle; at RESET_HOLD-1, go to PAUSE. A rst press while in RESET restarts the hold count.
  PAUSE: digits frozen. rst press -> RESET. sw_adj = 1 -> ADJUST. pause press -> RUN.
  RUN: on sec_evt, MM:SS increments in BCD with carries: ones 9->0 carries into tens; sec_tens 5->0 carries into minutes; 59:59 -> 00:00 wraps silently. rst -> RESET. sw_adj = 1 -> ADJUST. pause press -> PAUSE.
  ADJUST: on sec_evt, the selected field (SS or MM) increments 00..59 and wraps to 00 with no carry into the other field; blink toggles. sw_adj = 0 -> PAUSE with blink cleared. rst -> RESET. Pause presses are ignored.
- Simultaneous events: if sec_evt arrives in the same cycle as a transition out of RUN/ADJUST, the increment still applies using the old state. If it coincides with an rst press, the reset wins and digits clear.
- Latency: digits update on the clock edge at which sec_evt is high, so they are visible 1 cycle after the one_hz rise is sampled. div_state and running are registered and change 1 cycle after the triggering press pulse.
- sw_sel change mid-ADJUST takes effect on the next sec_evt.

Optional Feature:
Macro LAP_EN.
- Defined: adds input btn_lap, debounced like the other buttons. A lap press in RUN freezes the four digit outputs at the current value while internal counting continues. A second lap press, or leaving RUN, releases the freeze and shows the live count.
- Undefined: no btn_lap port; digit outputs always show the live count.

Test Plan:
- Reset release with RESET_HOLD = 2 -> div_state = 2 for 2 cycles, then 1 (PAUSE); digits 00:00; running = 0.
- Pause press held for 2 disp_ticks, then 3 one_hz edges -> div_state = 0, running = 1, display 00:03; a 1-tick glitch press produces no transition.
- Preload 59:58 in RUN, 2 one_hz edges -> 59:59, then 00:00.
- sw_adj = 1, sw_sel = 1, display at 58:10, 3 edges -> 59:10, 00:10, 01:10 (seconds unchanged); blink toggles 3 times; sw_adj = 0 -> PAUSE, blink = 0.
- rst press and sec_evt in the same cycle while RUN at 00:07 -> RESET, digits 00:00, div_state = 2.
- rst_n asserted mid-RUN at 12:34 -> immediate (async) div_state = 2, digits 00:00. With LAP_EN: lap press at 00:05, then 4 edges -> display holds 00:05; second press -> 00:09.
